// File: rtl/hyperbus_wb_bridge.sv
// hyperbus_wb_bridge: Wishbone classic slave splitting 32-bit accesses into two 16-bit hyperbus controller beats
module hyperbus_wb_bridge #(
    parameter int REG_SPACE_BIT = 31,
    parameter int TIMEOUT       = 1023
) (
    input  logic        clk,
    input  logic        rstn,
    input  logic [31:0] wb_adr_i,
    input  logic [31:0] wb_dat_i,
    input  logic [3:0]  wb_sel_i,
    input  logic        wb_we_i,
    input  logic        wb_cyc_i,
    input  logic        wb_stb_i,
    output logic [31:0] wb_dat_o,
    output logic        wb_ack_o,
    output logic        wb_err_o,
    output logic [31:0] hb_adr_o,
    output logic        hb_reg_space_o,
    output logic [15:0] hb_dat_o,
    input  logic [15:0] hb_dat_i,
    output logic        hb_rrq_o,
    output logic        hb_wrq_o,
    input  logic        hb_dready_i,
    input  logic        hb_dvalid_i,
    input  logic        hb_busy_i,
    input  logic        hb_error_i
);
    typedef enum logic [4:0] {
        IDLE = 5'b00001,
        REQ  = 5'b00010,
        BEAT = 5'b00100,
        DONE = 5'b01000,
        ERR  = 5'b10000
    } state_t;
    localparam logic [9:0] TMO = 10'(TIMEOUT);
    state_t      state, state_d;
    logic [31:0] wdata, rdata, adr_m;
    logic [9:0]  tcnt;
    logic        we, beat, busy_q, abort, accept, active, prog, touch, ok, ack_d, err_d;
    assign active   = state == REQ || state == BEAT || state == DONE;
    assign prog     = state == BEAT && (we ? hb_dready_i : hb_dvalid_i);
    assign touch    = hb_dready_i | hb_dvalid_i | (hb_busy_i ^ busy_q);
    assign ok       = wb_cyc_i && !abort;
    assign ack_d    = state == DONE && state_d == IDLE && ok;
    assign err_d    = state != ERR && state_d == ERR && ok;
    assign hb_dat_o = beat ? wdata[31:16] : wdata[15:0];
    always_comb begin
        adr_m = wb_adr_i;
        adr_m[REG_SPACE_BIT] = 1'b0;
    end
    always_comb begin
        state_d = state;
        accept  = 1'b0;
        case (state)
            IDLE: if (wb_cyc_i && wb_stb_i && !hb_busy_i && !wb_ack_o && !wb_err_o) begin
                accept  = 1'b1;
                state_d = (hb_error_i || (wb_we_i && wb_sel_i != 4'hF)) ? ERR : REQ;
            end
            REQ:     state_d = hb_busy_i ? BEAT : REQ;
            BEAT:    state_d = (beat && prog) ? DONE : BEAT;
            DONE:    state_d = hb_busy_i ? DONE : IDLE;
            default: state_d = IDLE;
        endcase
        // controller faults and stalls override any beat progress this cycle
        if (active && (hb_error_i || tcnt == TMO)) state_d = ERR;
    end
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) state <= IDLE;
        else       state <= state_d;
    end
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            wb_dat_o       <= '0;
            wb_ack_o       <= 1'b0;
            wb_err_o       <= 1'b0;
            hb_adr_o       <= '0;
            hb_reg_space_o <= 1'b0;
            hb_rrq_o       <= 1'b0;
            hb_wrq_o       <= 1'b0;
            wdata          <= '0;
            rdata          <= '0;
            tcnt           <= '0;
            we             <= 1'b0;
            beat           <= 1'b0;
            busy_q         <= 1'b0;
            abort          <= 1'b0;
        end else begin
            busy_q   <= hb_busy_i;
            tcnt     <= (state_d != state || touch || !active) ? '0 : tcnt + 10'd1;
            abort    <= state_d == IDLE ? 1'b0 : abort | (state != IDLE && !wb_cyc_i);
            wb_ack_o <= ack_d;
            wb_err_o <= err_d;
            if (ack_d) wb_dat_o <= rdata;
            if (accept && state_d == REQ) begin
                hb_adr_o       <= adr_m >> 1;
                hb_reg_space_o <= wb_adr_i[REG_SPACE_BIT];
                wdata          <= wb_dat_i;
                we             <= wb_we_i;
                beat           <= 1'b0;
                hb_rrq_o       <= !wb_we_i;
                hb_wrq_o       <= wb_we_i;
            end else if (state_d != REQ && state_d != BEAT) begin
                hb_rrq_o <= 1'b0;
                hb_wrq_o <= 1'b0;
            end
            if (prog && state_d != ERR) begin
                beat <= !beat;
                if (!we) rdata <= beat ? {hb_dat_i, rdata[15:0]} : {rdata[31:16], hb_dat_i};
            end
        end
    end
endmodule

// File: tb/tb_hyperbus_wb_bridge.sv
// tb_hyperbus_wb_bridge: directed self-checking bench for hyperbus_wb_bridge
module tb_hyperbus_wb_bridge;
    logic        clk = 1'b0, rstn = 1'b1;
    logic [31:0] wb_adr_i = '0, wb_dat_i = '0;
    logic [3:0]  wb_sel_i = '0;
    logic        wb_we_i = 1'b0, wb_cyc_i = 1'b0, wb_stb_i = 1'b0;
    logic [31:0] wb_dat_o, hb_adr_o;
    logic        wb_ack_o, wb_err_o, hb_reg_space_o, hb_rrq_o, hb_wrq_o;
    logic [15:0] hb_dat_o, hb_dat_i = '0;
    logic        hb_dready_i = 1'b0, hb_dvalid_i = 1'b0, hb_busy_i = 1'b0, hb_error_i = 1'b0;
    int          total = 0, bad = 0;

    always #5 clk = ~clk;

    hyperbus_wb_bridge dut (
        .clk(clk), .rstn(rstn),
        .wb_adr_i(wb_adr_i), .wb_dat_i(wb_dat_i), .wb_sel_i(wb_sel_i), .wb_we_i(wb_we_i),
        .wb_cyc_i(wb_cyc_i), .wb_stb_i(wb_stb_i), .wb_dat_o(wb_dat_o), .wb_ack_o(wb_ack_o),
        .wb_err_o(wb_err_o), .hb_adr_o(hb_adr_o), .hb_reg_space_o(hb_reg_space_o),
        .hb_dat_o(hb_dat_o), .hb_dat_i(hb_dat_i), .hb_rrq_o(hb_rrq_o), .hb_wrq_o(hb_wrq_o),
        .hb_dready_i(hb_dready_i), .hb_dvalid_i(hb_dvalid_i), .hb_busy_i(hb_busy_i),
        .hb_error_i(hb_error_i)
    );

    task automatic start(input logic [31:0] adr, input logic [31:0] dat, input logic [3:0] sel, input logic we);
        wb_adr_i = adr; wb_dat_i = dat; wb_sel_i = sel; wb_we_i = we; wb_cyc_i = 1'b1; wb_stb_i = 1'b1;
    endtask

    task automatic drop();
        wb_cyc_i = 1'b0; wb_stb_i = 1'b0;
    endtask

    task automatic wait_req(output logic got);
        got = 1'b0;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            if (hb_rrq_o || hb_wrq_o) begin got = 1'b1; break; end
        end
    endtask

    task automatic do_access(input logic [31:0] adr, input logic [31:0] wdat, input logic we,
                             input logic [15:0] b0, input logic [15:0] b1,
                             output logic ok, output logic [31:0] rd);
        logic got;
        ok = 1'b0; rd = '0;
        @(negedge clk); start(adr, wdat, 4'hF, we);
        wait_req(got);
        if (got) begin
            hb_busy_i = 1'b1;
            @(negedge clk); hb_dready_i = we; hb_dvalid_i = !we; hb_dat_i = b0;
            @(negedge clk); hb_dat_i = b1;
            @(negedge clk); hb_dready_i = 1'b0; hb_dvalid_i = 1'b0; hb_busy_i = 1'b0;
            for (int i = 0; i < 5; i++) begin
                @(negedge clk);
                if (wb_ack_o) begin ok = 1'b1; rd = wb_dat_o; break; end
            end
        end
        drop();
    endtask

    task automatic test_reset();
        #1 rstn = 1'b0;
        #2;
        total++; if ({wb_ack_o, wb_err_o, hb_rrq_o, hb_wrq_o, hb_reg_space_o} !== 5'b0) begin bad++; $display("FAIL rst_ctl got=%b exp=00000", {wb_ack_o, wb_err_o, hb_rrq_o, hb_wrq_o, hb_reg_space_o}); end
        total++; if ({wb_dat_o, hb_adr_o, hb_dat_o} !== 80'h0) begin bad++; $display("FAIL rst_data got=%h exp=0", {wb_dat_o, hb_adr_o, hb_dat_o}); end
        repeat (2) @(negedge clk);
        rstn = 1'b1;
        @(negedge clk);
    endtask

    task automatic test_write();
        @(negedge clk); hb_busy_i = 1'b0; start(32'h0000_0010, 32'hA5A5_1234, 4'hF, 1'b1);
        @(negedge clk);
        total++; if ({hb_wrq_o, hb_rrq_o} !== 2'b10) begin bad++; $display("FAIL wr_req got=%b exp=10", {hb_wrq_o, hb_rrq_o}); end
        total++; if (hb_adr_o !== 32'h8) begin bad++; $display("FAIL wr_adr got=%h exp=8", hb_adr_o); end
        total++; if (hb_reg_space_o !== 1'b0) begin bad++; $display("FAIL wr_space got=%b exp=0", hb_reg_space_o); end
        hb_busy_i = 1'b1;
        @(negedge clk);
        total++; if (hb_dat_o !== 16'h1234) begin bad++; $display("FAIL wr_beat0 got=%h exp=1234", hb_dat_o); end
        hb_dready_i = 1'b1;
        @(negedge clk);
        total++; if (hb_dat_o !== 16'hA5A5 || hb_wrq_o !== 1'b1) begin bad++; $display("FAIL wr_beat1 got=%h/%b exp=a5a5/1", hb_dat_o, hb_wrq_o); end
        @(negedge clk); hb_dready_i = 1'b0;
        total++; if (hb_wrq_o !== 1'b0) begin bad++; $display("FAIL wr_drop got=%b exp=0", hb_wrq_o); end
        @(negedge clk);
        total++; if (wb_ack_o !== 1'b0) begin bad++; $display("FAIL wr_early_ack got=%b exp=0", wb_ack_o); end
        hb_busy_i = 1'b0;
        @(negedge clk);
        total++; if (wb_ack_o !== 1'b1) begin bad++; $display("FAIL wr_ack got=%b exp=1", wb_ack_o); end
        drop();
        @(negedge clk);
        total++; if (wb_ack_o !== 1'b0) begin bad++; $display("FAIL wr_ack_pulse got=%b exp=0", wb_ack_o); end
    endtask

    task automatic test_read();
        logic got;
        @(negedge clk); start(32'h8000_0004, 32'h0, 4'hF, 1'b0);
        wait_req(got);
        total++; if ({hb_rrq_o, hb_wrq_o, hb_reg_space_o} !== 3'b101) begin bad++; $display("FAIL rd_req got=%b exp=101", {hb_rrq_o, hb_wrq_o, hb_reg_space_o}); end
        total++; if (hb_adr_o !== 32'h2) begin bad++; $display("FAIL rd_adr got=%h exp=2", hb_adr_o); end
        hb_busy_i = 1'b1;
        @(negedge clk); hb_dvalid_i = 1'b1; hb_dat_i = 16'hBEEF;
        @(negedge clk); hb_dat_i = 16'hCAFE;
        @(negedge clk); hb_dvalid_i = 1'b0; hb_busy_i = 1'b0;
        total++; if (hb_rrq_o !== 1'b0) begin bad++; $display("FAIL rd_drop got=%b exp=0", hb_rrq_o); end
        @(negedge clk);
        total++; if (wb_ack_o !== 1'b1 || wb_dat_o !== 32'hCAFE_BEEF) begin bad++; $display("FAIL rd_ack got=%b/%h exp=1/cafebeef", wb_ack_o, wb_dat_o); end
        drop();
        @(negedge clk);
    endtask

    task automatic test_sel_err();
        logic seen_err = 1'b0, seen_req = 1'b0;
        @(negedge clk); start(32'h20, 32'h1, 4'h3, 1'b1);
        for (int i = 0; i < 2; i++) begin
            @(negedge clk);
            if (hb_rrq_o || hb_wrq_o) seen_req = 1'b1;
            if (wb_err_o) begin seen_err = 1'b1; break; end
        end
        drop();
        repeat (3) begin @(negedge clk); if (hb_rrq_o || hb_wrq_o) seen_req = 1'b1; end
        total++; if (seen_err !== 1'b1) begin bad++; $display("FAIL sel_err got=%b exp=1", seen_err); end
        total++; if (seen_req !== 1'b0) begin bad++; $display("FAIL sel_noreq got=%b exp=0", seen_req); end
    endtask

    task automatic test_timeout();
        logic got, ok;
        logic [31:0] rd;
        int n = 0;
        @(negedge clk); start(32'h40, 32'h0, 4'hF, 1'b0);
        wait_req(got);
        total++; if (got !== 1'b1) begin bad++; $display("FAIL to_req got=%b exp=1", got); end
        hb_busy_i = 1'b1;
        for (int i = 0; i < 1100; i++) begin
            @(negedge clk); n++;
            if (wb_err_o) break;
        end
        total++; if (n < 1023 || n > 1027 || wb_err_o !== 1'b1) begin bad++; $display("FAIL to_err cycles=%0d err=%b exp=1023..1027/1", n, wb_err_o); end
        total++; if (hb_rrq_o !== 1'b0) begin bad++; $display("FAIL to_rrq got=%b exp=0", hb_rrq_o); end
        drop();
        @(negedge clk); hb_busy_i = 1'b0;
        do_access(32'h44, 32'h1111_2222, 1'b1, 16'h0, 16'h0, ok, rd);
        total++; if (ok !== 1'b1) begin bad++; $display("FAIL to_recover got=%b exp=1", ok); end
    endtask

    task automatic test_hb_error();
        logic got, seen_err = 1'b0, seen_req = 1'b0;
        @(negedge clk); start(32'h80, 32'h0, 4'hF, 1'b0);
        wait_req(got);
        hb_busy_i = 1'b1;
        @(negedge clk); hb_error_i = 1'b1; hb_dvalid_i = 1'b1; hb_dat_i = 16'h1111;
        @(negedge clk); hb_dvalid_i = 1'b0;
        total++; if (wb_err_o !== 1'b1 || hb_rrq_o !== 1'b0) begin bad++; $display("FAIL he_err got=%b/%b exp=1/0", wb_err_o, hb_rrq_o); end
        total++; if (wb_dat_o !== 32'hCAFE_BEEF) begin bad++; $display("FAIL he_dat got=%h exp=cafebeef", wb_dat_o); end
        drop();
        @(negedge clk);
        total++; if (wb_err_o !== 1'b0) begin bad++; $display("FAIL he_pulse got=%b exp=0", wb_err_o); end
        hb_busy_i = 1'b0;
        @(negedge clk); start(32'h84, 32'h5, 4'hF, 1'b1);
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            if (hb_rrq_o || hb_wrq_o) seen_req = 1'b1;
            if (wb_err_o) begin seen_err = 1'b1; break; end
        end
        drop();
        total++; if ({seen_err, seen_req} !== 2'b10) begin bad++; $display("FAIL he_sticky got=%b exp=10", {seen_err, seen_req}); end
        @(negedge clk); hb_error_i = 1'b0;
    endtask

    task automatic test_reset_mid();
        logic got, seen = 1'b0;
        @(negedge clk); start(32'h100, 32'h55AA_33CC, 4'hF, 1'b1);
        wait_req(got);
        hb_busy_i = 1'b1;
        @(negedge clk);
        #2 rstn = 1'b0;
        #1;
        total++; if ({hb_wrq_o, hb_rrq_o, wb_ack_o, wb_err_o} !== 4'b0 || hb_adr_o !== 32'h0 || hb_dat_o !== 16'h0) begin bad++; $display("FAIL mid_rst got=%b/%h/%h exp=0", {hb_wrq_o, hb_rrq_o, wb_ack_o, wb_err_o}, hb_adr_o, hb_dat_o); end
        @(negedge clk); drop(); hb_busy_i = 1'b0; rstn = 1'b1;
        repeat (4) begin @(negedge clk); if (wb_ack_o || wb_err_o) seen = 1'b1; end
        total++; if (seen !== 1'b0) begin bad++; $display("FAIL mid_rst_resp got=%b exp=0", seen); end
    endtask

    task automatic test_abort();
        logic got, seen = 1'b0;
        @(negedge clk); start(32'h200, 32'h0, 4'hF, 1'b0);
        wait_req(got);
        hb_busy_i = 1'b1;
        @(negedge clk); hb_dvalid_i = 1'b1; hb_dat_i = 16'h1357;
        @(negedge clk); hb_dvalid_i = 1'b0; drop();
        @(negedge clk);
        total++; if (hb_rrq_o !== 1'b1) begin bad++; $display("FAIL ab_hold got=%b exp=1", hb_rrq_o); end
        hb_dvalid_i = 1'b1; hb_dat_i = 16'h2468;
        @(negedge clk); hb_dvalid_i = 1'b0; hb_busy_i = 1'b0;
        total++; if (hb_rrq_o !== 1'b0) begin bad++; $display("FAIL ab_done got=%b exp=0", hb_rrq_o); end
        repeat (4) begin @(negedge clk); if (wb_ack_o || wb_err_o) seen = 1'b1; end
        total++; if (seen !== 1'b0) begin bad++; $display("FAIL ab_noack got=%b exp=0", seen); end
    endtask

    task automatic test_back_to_back();
        logic got, ok;
        logic [31:0] rd;
        @(negedge clk); start(32'h300, 32'h0, 4'hF, 1'b0);
        wait_req(got);
        hb_busy_i = 1'b1;
        @(negedge clk); hb_dvalid_i = 1'b1; hb_dat_i = 16'h0001;
        @(negedge clk); hb_dat_i = 16'h0002;
        @(negedge clk); hb_dvalid_i = 1'b0; hb_busy_i = 1'b0;
        @(negedge clk);
        total++; if (wb_ack_o !== 1'b1 || wb_dat_o !== 32'h0002_0001) begin bad++; $display("FAIL b2b_first got=%b/%h exp=1/00020001", wb_ack_o, wb_dat_o); end
        start(32'h304, 32'h0, 4'hF, 1'b0);
        @(negedge clk);
        total++; if (hb_rrq_o !== 1'b0 || wb_ack_o !== 1'b0) begin bad++; $display("FAIL b2b_gap got=%b/%b exp=0/0", hb_rrq_o, wb_ack_o); end
        @(negedge clk);
        total++; if (hb_rrq_o !== 1'b1 || hb_adr_o !== 32'h182) begin bad++; $display("FAIL b2b_second got=%b/%h exp=1/182", hb_rrq_o, hb_adr_o); end
        drop();
        do_access(32'h308, 32'h0, 1'b0, 16'h0003, 16'h0004, ok, rd);
        total++; if (ok !== 1'b0) begin bad++; $display("FAIL b2b_hung got=%b exp=0", ok); end
        hb_busy_i = 1'b1;
        @(negedge clk); hb_dvalid_i = 1'b1; hb_dat_i = 16'h0003;
        @(negedge clk); hb_dat_i = 16'h0004;
        @(negedge clk); hb_dvalid_i = 1'b0; hb_busy_i = 1'b0;
        repeat (2) @(negedge clk);
        do_access(32'h30C, 32'h0, 1'b0, 16'h0005, 16'h0006, ok, rd);
        total++; if (ok !== 1'b1 || rd !== 32'h0006_0005) begin bad++; $display("FAIL b2b_third got=%b/%h exp=1/00060005", ok, rd); end
    endtask

    initial begin
        test_reset();
        test_write();
        test_read();
        test_sel_err();
        test_timeout();
        test_hb_error();
        test_reset_mid();
        test_abort();
        test_back_to_back();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
